wb_rr_arbiter: RTL



---
 rtl/wb_rr_arbiter.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/wb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_rr_arbiter
// Purpose  : Four-port round-robin arbiter that shares one pipelined Wishbone
//            master port between four requesters. Ownership is held while
//            the owner keeps cyc high. Strobes that are accepted but not yet
//            acked are counted in an outstanding-transfer counter.
//            Optional burst limit (macro ARB_BURST_LIMIT_EN): once the owner
//            has had MAX_XFERS strobes accepted and another port is
//            requesting, the owner is stalled. Its in-flight acks drain, and
//            then the bus is rearbitrated.
// Ports    : clk_i, rst_i               clock, synchronous active-high reset
//            in_cyc/stb/we/adr/sel/dat_m requester inputs, packed [3:0] per port
//            in_ack/stall/dat_s         requester outputs, packed [3:0] per port
//            out_cyc/stb/we/adr/sel/dat_m shared master outputs
//            out_ack/stall/dat_s        shared master inputs
//            grant                      index of current/last owner
//            busy                       high while a port owns the bus
// Revision : 1.0  initial release
// ============================================================================
module wb_rr_arbiter #(
    parameter int MAX_XFERS = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    // requester ports
    input  logic [3:0]       in_cyc,
    input  logic [3:0]       in_stb,
    input  logic [3:0]       in_we,
    input  logic [3:0][31:0] in_adr,
    input  logic [3:0][3:0]  in_sel,
    input  logic [3:0][31:0] in_dat_m,
    output logic [3:0]       in_ack,
    output logic [3:0]       in_stall,
    output logic [3:0][31:0] in_dat_s,
    // shared master port
    output logic             out_cyc,
    output logic             out_stb,
    output logic             out_we,
    output logic [31:0]      out_adr,
    output logic [3:0]       out_sel,
    output logic [31:0]      out_dat_m,
    input  logic             out_ack,
    input  logic             out_stall,
    input  logic [31:0]      out_dat_s,
    // status
    output logic [1:0]       grant,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OWN   = 2'd1,
        S_DRAIN = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    if (MAX_XFERS < 1 || MAX_XFERS > 255) begin : g_max_xfers_check
        $error("wb_rr_arbiter: MAX_XFERS must be in 1..255");
    end

    state_t     r_state;
    logic [1:0] r_last;
    logic [1:0] r_owner;
    logic [7:0] r_outst;

    logic [1:0] w_winner;
    logic [1:0] w_idx;
    logic       w_found;
    logic       w_active;
    logic       w_accept;
    logic       w_limit_hit;
    logic [7:0] w_outst_next;

    // Round-robin search starting one past the last owner. Adding 4 wraps
    // back to the last owner itself, so it is considered last.
    always_comb begin
        w_winner = r_last;
        w_found  = 1'b0;
        w_idx    = r_last;
        for (int i = 1; i <= 4; i++) begin
            w_idx = r_last + 2'(i);
            if (!w_found && in_cyc[w_idx]) begin
                w_winner = w_idx;
                w_found  = 1'b1;
            end
        end
    end

    assign w_active = (r_state == S_OWN) || (r_state == S_DRAIN);
    assign w_accept = out_stb & ~out_stall;

`ifdef ARB_BURST_LIMIT_EN
    logic [7:0] r_xfer_cnt;
    logic [3:0] w_owner_mask;

    assign w_owner_mask = 4'b0001 << r_owner;
    // Stalling the owner in the same cycle that the limit is reached
    // prevents one extra strobe from slipping through before S_DRAIN.
    assign w_limit_hit  = (r_state == S_OWN) &&
                          (r_xfer_cnt >= 8'(MAX_XFERS)) &&
                          (|(in_cyc & ~w_owner_mask));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_xfer_cnt <= 8'd0;
        end else if (r_state == S_IDLE) begin
            r_xfer_cnt <= 8'd0;
        end else if (r_state == S_OWN && w_accept && r_xfer_cnt != 8'hFF) begin
            r_xfer_cnt <= r_xfer_cnt + 8'd1;
        end
    end
`else
    assign w_limit_hit = 1'b0;
`endif

    // An accept and an ack in the same cycle cancel out.
    always_comb begin
        case ({w_accept, out_ack})
            2'b10:   w_outst_next = r_outst + 8'd1;
            2'b01:   w_outst_next = r_outst - 8'd1;
            default: w_outst_next = r_outst;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_last  <= 2'd3;
            r_owner <= 2'd0;
            r_outst <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|in_cyc) begin
                        r_owner <= w_winner;
                        r_last  <= w_winner;
                        r_outst <= 8'd0;
                        r_state <= S_OWN;
                    end
                end
                S_OWN: begin
                    if (!in_cyc[r_owner]) begin
                        // Pending acks are abandoned with the cycle.
                        r_outst <= 8'd0;
                        r_state <= S_GAP;
                    end else begin
                        r_outst <= w_outst_next;
                        if (w_limit_hit) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!in_cyc[r_owner] || w_outst_next == 8'd0) begin
                        r_outst <= 8'd0;
                        r_state <= S_GAP;
                    end else begin
                        r_outst <= w_outst_next;
                    end
                end
                S_GAP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Owner mux. Outside ownership everything is parked low and every
    // requester is stalled, so late acks in S_GAP/S_IDLE reach nobody.
    always_comb begin
        out_cyc   = 1'b0;
        out_stb   = 1'b0;
        out_we    = 1'b0;
        out_adr   = 32'd0;
        out_sel   = 4'd0;
        out_dat_m = 32'd0;
        in_ack    = 4'b0000;
        in_stall  = 4'b1111;
        if (w_active) begin
            out_cyc          = in_cyc[r_owner];
            out_we           = in_we[r_owner];
            out_adr          = in_adr[r_owner];
            out_sel          = in_sel[r_owner];
            out_dat_m        = in_dat_m[r_owner];
            in_ack[r_owner]  = out_ack;
        end
        if (r_state == S_OWN) begin
            out_stb           = in_stb[r_owner] & ~w_limit_hit;
            in_stall[r_owner] = out_stall | w_limit_hit;
        end
    end

    assign in_dat_s = {4{out_dat_s}};
    assign grant    = r_last;
    assign busy     = w_active;

endmodule
`default_nettype wire
